// File: rtl/sdcard_spi_arbiter.sv
// -----------------------------------------------------------------------------
// sdcard_spi_arbiter
//
// Shares one SD-card SPI channel between two SPI masters. Port A is the Next
// core master and port B is the board-management / boot-loader master. Access
// uses a level request/grant handshake. When both ports request at once, the
// grant goes to the port that did not own the bus last. Between two owners the
// bus is held idle for a guard gap. An owner that stays idle while the other
// port is waiting has its grant revoked.
//
// Ports:
//   clk_peripheral            peripheral clock; all requester signals are
//                             synchronous to it
//   resetn                    asynchronous, active-low reset
//   a_req / b_req             level requests
//   a_gnt / b_gnt             registered grants
//   a_sck, a_mosi, a_cs_n     port A SPI master outputs (used only while granted)
//   b_sck, b_mosi, b_cs_n     port B SPI master outputs (used only while granted)
//   a_miso / b_miso           MISO back to each port (1 when that port is not owner)
//   out_sck, out_mosi         to the SD sequencing block
//   out_cs_n                  to the SD sequencing block (drives its enable_n)
//   out_miso                  from the SD sequencing block
//   owner                     00 none/guard, 01 A, 10 B
//   revoked                   one-cycle pulse when a grant is removed by timeout
// -----------------------------------------------------------------------------
module sdcard_spi_arbiter #(
  parameter int GUARD_CYCLES      = 16,  // legal range 1..255
  parameter int IDLE_TIMEOUT_BITS = 16
) (
  input  logic       clk_peripheral,
  input  logic       resetn,
  input  logic       a_req,
  output logic       a_gnt,
  input  logic       a_sck,
  input  logic       a_mosi,
  input  logic       a_cs_n,
  output logic       a_miso,
  input  logic       b_req,
  output logic       b_gnt,
  input  logic       b_sck,
  input  logic       b_mosi,
  input  logic       b_cs_n,
  output logic       b_miso,
  output logic       out_sck,
  output logic       out_mosi,
  output logic       out_cs_n,
  input  logic       out_miso,
  output logic [1:0] owner,
  output logic       revoked
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OWN_A = 2'b01,
    S_OWN_B = 2'b10,
    S_GUARD = 2'b11
  } state_t;

  localparam logic [7:0]                   GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam logic [IDLE_TIMEOUT_BITS-1:0] IDLE_ONE   = IDLE_TIMEOUT_BITS'(1);

  state_t                       state, state_nxt;
  logic                         last_b;     // 1: B was the most recent owner
  logic [7:0]                   guard_cnt;
  logic [IDLE_TIMEOUT_BITS-1:0] idle_cnt;
  logic [IDLE_TIMEOUT_BITS-1:0] idle_inc;

  logic own_req;
  logic own_cs_n;
  logic other_req;
  logic in_own;
  logic idle_qual;
  logic timeout;
  logic leave_own;

  // Signals from the current owner. Outside the OWN states, the defaults keep
  // the idle counter and the timeout logic inactive.
  // NOTE: every signal driven in an always_comb block gets a default value
  // first. Without the default, a path that does not assign the signal
  // would infer a latch.
  always_comb begin
    own_req   = 1'b0;
    own_cs_n  = 1'b1;
    other_req = 1'b0;
    case (state)
      S_OWN_A: begin own_req = a_req; own_cs_n = a_cs_n; other_req = b_req; end
      S_OWN_B: begin own_req = b_req; own_cs_n = b_cs_n; other_req = a_req; end
      default: ;
    endcase
  end

  assign in_own    = (state == S_OWN_A) || (state == S_OWN_B);
  // An idle cycle counts only while the other port waits and no frame is
  // open, so a grant is never revoked in the middle of a frame.
  assign idle_qual = other_req && own_cs_n;
  assign idle_inc  = idle_cnt + IDLE_ONE;
  // The counter reaches all-ones on this edge, which is the
  // (2^IDLE_TIMEOUT_BITS-1)th consecutive idle cycle.
  assign timeout   = idle_qual && (idle_inc == '1);
  // A release by the owner takes priority over a timeout in the same cycle.
  assign leave_own = in_own && (!own_req || timeout);

  // ---------------------------------------------------------------------------
  // State register, counters and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      last_b    <= 1'b1;
      guard_cnt <= '0;
      idle_cnt  <= '0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      revoked   <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_gnt   <= (state_nxt == S_OWN_A);
      b_gnt   <= (state_nxt == S_OWN_B);
      revoked <= in_own && own_req && timeout;

      if (leave_own) begin
        last_b    <= (state == S_OWN_B);
        guard_cnt <= GUARD_LOAD;
      end else if ((state == S_GUARD) && (guard_cnt != 8'd0)) begin
        guard_cnt <= guard_cnt - 8'd1;
      end

      if (in_own && idle_qual && !leave_own) idle_cnt <= idle_inc;
      else                                   idle_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (a_req && b_req) state_nxt = last_b ? S_OWN_A : S_OWN_B;
        else if (a_req)     state_nxt = S_OWN_A;
        else if (b_req)     state_nxt = S_OWN_B;
      end
      S_OWN_A, S_OWN_B: if (leave_own)          state_nxt = S_GUARD;
      S_GUARD:          if (guard_cnt == 8'd0)  state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SPI mux, selected by the registered state. Any state other than an OWN
  // state drives the idle bus values.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_sck  = 1'b0;
    out_mosi = 1'b1;
    out_cs_n = 1'b1;
    a_miso   = 1'b1;
    b_miso   = 1'b1;
    case (state)
      S_OWN_A: begin
        out_sck  = a_sck;
        out_mosi = a_mosi;
        out_cs_n = a_cs_n;
        a_miso   = out_miso;
      end
      S_OWN_B: begin
        out_sck  = b_sck;
        out_mosi = b_mosi;
        out_cs_n = b_cs_n;
        b_miso   = out_miso;
      end
      default: ;
    endcase
  end

  assign owner = {b_gnt, a_gnt};

endmodule

// File: tb/tb_sdcard_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdcard_spi_arbiter
//
// Self-checking bench for sdcard_spi_arbiter, built with GUARD_CYCLES=16 and
// IDLE_TIMEOUT_BITS=4. A behavioural model tracks ownership as "who owns,
// guard cycles left, idle run length, last owner". On every falling edge the
// bench checks all DUT outputs against that model. Directed sequences also
// check hand-computed latencies and values.
// -----------------------------------------------------------------------------
module tb_sdcard_spi_arbiter;

  localparam int G  = 16;
  localparam int W  = 4;
  localparam int TO = (1 << W) - 1;  // idle cycles before revocation

  logic       clk_peripheral = 1'b0;
  logic       resetn;
  logic       a_req, a_sck, a_mosi, a_cs_n;
  logic       b_req, b_sck, b_mosi, b_cs_n;
  logic       out_miso;
  logic       a_gnt, b_gnt, a_miso, b_miso;
  logic       out_sck, out_mosi, out_cs_n, revoked;
  logic [1:0] owner;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  sdcard_spi_arbiter #(
    .GUARD_CYCLES      (G),
    .IDLE_TIMEOUT_BITS (W)
  ) dut (
    .clk_peripheral (clk_peripheral),
    .resetn         (resetn),
    .a_req          (a_req),
    .a_gnt          (a_gnt),
    .a_sck          (a_sck),
    .a_mosi         (a_mosi),
    .a_cs_n         (a_cs_n),
    .a_miso         (a_miso),
    .b_req          (b_req),
    .b_gnt          (b_gnt),
    .b_sck          (b_sck),
    .b_mosi         (b_mosi),
    .b_cs_n         (b_cs_n),
    .b_miso         (b_miso),
    .out_sck        (out_sck),
    .out_mosi       (out_mosi),
    .out_cs_n       (out_cs_n),
    .out_miso       (out_miso),
    .owner          (owner),
    .revoked        (revoked)
  );

  always #5 clk_peripheral = ~clk_peripheral;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. own: 0 nobody, 1 A, 2 B. guard > 0 means the bus is in
  // its guard gap with that many cycles left. run counts consecutive cycles in
  // which the owner is idle while the other port waits.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int   own;
    int   guard;
    int   last;
    int   run;
    logic rev;
  } model_t;

  localparam model_t M_RESET = '{own: 0, guard: 0, last: 2, run: 0, rev: 1'b0};

  model_t m;

  function automatic model_t model_step(input model_t s, input logic ar, input logic br,
                                        input logic acs, input logic bcs);
    model_t n;
    logic   my_req, oth_req, my_cs;
    n     = s;
    n.rev = 1'b0;
    if (s.guard > 0) begin
      n.guard = s.guard - 1;
    end else if (s.own == 0) begin
      n.run = 0;
      if (ar && br)  n.own = (s.last == 1) ? 2 : 1;
      else if (ar)   n.own = 1;
      else if (br)   n.own = 2;
    end else begin
      my_req  = (s.own == 1) ? ar  : br;
      oth_req = (s.own == 1) ? br  : ar;
      my_cs   = (s.own == 1) ? acs : bcs;
      if (!my_req) begin
        n.own = 0; n.guard = G; n.last = s.own; n.run = 0;
      end else if (oth_req && my_cs) begin
        if (s.run + 1 == TO) begin
          n.own = 0; n.guard = G; n.last = s.own; n.run = 0; n.rev = 1'b1;
        end else begin
          n.run = s.run + 1;
        end
      end else begin
        n.run = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn) m <= M_RESET;
    else         m <= model_step(m, a_req, b_req, a_cs_n, b_cs_n);
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk_peripheral) begin
    if (started) begin
      check("a_gnt",    a_gnt,   32'(m.own == 1));
      check("b_gnt",    b_gnt,   32'(m.own == 2));
      check("owner",    owner,   32'(m.own));
      check("revoked",  revoked, 32'(m.rev));
      check("out_sck",  out_sck,  (m.own == 1) ? a_sck  : (m.own == 2) ? b_sck  : 1'b0);
      check("out_mosi", out_mosi, (m.own == 1) ? a_mosi : (m.own == 2) ? b_mosi : 1'b1);
      check("out_cs_n", out_cs_n, (m.own == 1) ? a_cs_n : (m.own == 2) ? b_cs_n : 1'b1);
      check("a_miso",   a_miso,   (m.own == 1) ? out_miso : 1'b1);
      check("b_miso",   b_miso,   (m.own == 2) ? out_miso : 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_peripheral);
    #1;
    out_miso = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    a_req = 0; a_sck = 0; a_mosi = 1; a_cs_n = 1;
    b_req = 0; b_sck = 0; b_mosi = 1; b_cs_n = 1;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    step();
    step();
    resetn = 1;
    step();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return a_gnt;
      1:       return b_gnt;
      2:       return revoked;
      default: return a_gnt | b_gnt;
    endcase
  endfunction

  // Steps the clock until the selected signal is high. Returns the number of
  // edges taken, or stops at the budget.
  task automatic wait_edges(input int which, input int budget, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!sig(which) && edges < budget);
    if (!sig(which)) check("wait_timeout", 32'(which), 32'hFFFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, who, rev_seen;
    out_miso = 0;
    resetn   = 0;
    idle_inputs();
    started  = 1'b1;

    // ---- 1: reset values, basic grant to A, pass-through ----
    step();
    check("rst_a_gnt",    a_gnt,    0);
    check("rst_b_gnt",    b_gnt,    0);
    check("rst_owner",    owner,    0);
    check("rst_revoked",  revoked,  0);
    check("rst_out_cs_n", out_cs_n, 1);
    check("rst_out_sck",  out_sck,  0);
    check("rst_out_mosi", out_mosi, 1);
    step();
    resetn = 1;
    step();
    a_req = 1;
    step();
    check("t1_a_gnt", a_gnt, 1);
    check("t1_owner", owner, 2'b01);
    for (int i = 0; i < 6; i++) begin
      a_cs_n = 0;
      a_sck  = 1'(i % 2);
      a_mosi = 1'((i / 2) % 2);
      #1;
      check("t1_out_sck",  out_sck,  32'(i % 2));
      check("t1_out_mosi", out_mosi, 32'((i / 2) % 2));
      check("t1_a_miso",   a_miso,   out_miso);
      check("t1_b_miso",   b_miso,   1);
      step();
    end
    a_cs_n = 1; a_sck = 0; a_req = 0;
    step();
    check("t1_rel_gnt",   a_gnt,    0);
    check("t1_rel_owner", owner,    0);
    check("t1_rel_cs",    out_cs_n, 1);
    repeat (20) step();

    // ---- 2: simultaneous requests, guard gap ----
    do_reset();
    a_req = 1; b_req = 1;
    step();
    check("t2_a_first", a_gnt, 1);
    check("t2_b_wait",  b_gnt, 0);
    a_cs_n = 0;
    repeat (3) step();
    a_cs_n = 1; a_req = 0;
    step();  // release sampled on this edge
    wait_edges(1, 40, e);
    check("t2_b_gnt_cycle", 32'(e + 1), 18);
    b_req = 0;
    repeat (20) step();

    // ---- 3: idle-timeout revocation ----
    do_reset();
    a_req = 1;
    step();
    b_req = 1;
    wait_edges(2, 40, e);
    check("t3_rev_after", 32'(e), 15);
    check("t3_a_gnt",     a_gnt, 0);
    check("t3_owner",     owner, 0);
    a_req = 0;
    wait_edges(1, 40, e);
    check("t3_b_gnt_after", 32'(e), 17);
    b_req = 0;
    repeat (20) step();

    // ---- 4: no revocation mid-frame; revoked A still requesting loses ----
    do_reset();
    a_req = 1;
    step();
    a_cs_n = 0; b_req = 1;
    rev_seen = 0;
    repeat (1000) begin
      step();
      if (revoked) rev_seen++;
    end
    check("t4_no_rev", 32'(rev_seen), 0);
    check("t4_a_held", a_gnt, 1);
    a_cs_n = 1;
    wait_edges(2, 40, e);
    check("t4_rev_after", 32'(e), 15);
    wait_edges(1, 40, e);
    check("t4_b_wins",  32'(e), 17);
    check("t4_a_loses", a_gnt, 0);
    b_req = 0;
    wait_edges(0, 40, e);
    check("t4_a_back", 32'(e), 18);
    a_req = 0;
    repeat (20) step();

    // ---- 5: both held, grants alternate ----
    do_reset();
    a_req = 1; b_req = 1;
    for (int g = 0; g < 6; g++) begin
      wait_edges(3, 40, e);
      who = a_gnt ? 1 : 2;
      check("t5_order", 32'(who), (g % 2 == 0) ? 1 : 2);
      if (who == 1) begin
        a_cs_n = 0; a_sck = 1; step(); a_sck = 0; step();
        a_cs_n = 1; a_req = 0; step(); a_req = 1;
      end else begin
        b_cs_n = 0; b_sck = 1; step(); b_sck = 0; step();
        b_cs_n = 1; b_req = 0; step(); b_req = 1;
      end
    end
    idle_inputs();
    repeat (20) step();

    // ---- 6: asynchronous reset while B owns mid-frame ----
    do_reset();
    b_req = 1;
    step();
    check("t6_b_gnt", b_gnt, 1);
    b_cs_n = 0; b_sck = 1; b_mosi = 0; a_req = 1;
    #1;
    check("t6_cs_live",  out_cs_n, 0);
    check("t6_sck_live", out_sck,  1);
    #1;
    resetn = 0;
    #1;
    check("t6_rst_cs",   out_cs_n, 1);
    check("t6_rst_sck",  out_sck,  0);
    check("t6_rst_mosi", out_mosi, 1);
    check("t6_rst_bgnt", b_gnt,    0);
    b_cs_n = 1; b_sck = 0; b_mosi = 1;
    step();
    resetn = 1;
    step();
    check("t6_a_first", a_gnt, 1);
    check("t6_b_not",   b_gnt, 0);
    idle_inputs();
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
